// File: rtl/mem_port_arbiter.sv
// Shares one unified memory port between the instruction-fetch (I) and data (D) requesters.
// Latency: grant in cycle N, mem_req from N+1, rvalid two cycles after grant plus wait states.
// Backpressure: requesters hold req until gnt; no grant while busy; watchdog aborts hung accesses.
module mem_port_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_gnt,
    output logic          i_rvalid,
    output logic [DW-1:0] i_rdata,
    output logic          i_err,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rdata,
    output logic          d_err,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack,
    output logic          busy,
    output logic          owner
);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } mem_cmd_t;

    // Counter only needs to reach TIMEOUT-1: the abort fires on that cycle.
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

    state_t        state, state_nxt;
    mem_cmd_t      cmd_q;
    logic          owner_q;
    logic          mem_req_q;
    logic          err_q;
    logic [CW-1:0] wdog_cnt;
    logic [DW-1:0] i_rdata_q, d_rdata_q;
    logic          timeout_hit;

    // An ack on the same cycle as the timeout takes precedence.
    assign timeout_hit = (TIMEOUT != 0) && (state == WAIT) && !mem_ack && (wdog_cnt == CNT_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        i_gnt     = 1'b0;
        d_gnt     = 1'b0;
        case (state)
            IDLE: begin
                // On a tie the requester that did not own the port last wins.
                if (i_req && (!d_req || owner_q)) begin
                    i_gnt     = 1'b1;
                    state_nxt = WAIT;
                end else if (d_req) begin
                    d_gnt     = 1'b1;
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (mem_ack || timeout_hit) begin
                    state_nxt = RESP;
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            owner_q   <= 1'b1;
            cmd_q     <= '0;
            mem_req_q <= 1'b0;
            err_q     <= 1'b0;
            wdog_cnt  <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_gnt || d_gnt) begin
                        owner_q   <= d_gnt;
                        mem_req_q <= 1'b1;
                        wdog_cnt  <= '0;
                        if (d_gnt) begin
                            cmd_q <= mem_cmd_t'{we: d_we, addr: d_addr, wdata: d_wdata};
                        end else begin
                            cmd_q <= mem_cmd_t'{we: 1'b0, addr: i_addr, wdata: '0};
                        end
                    end
                end
                WAIT: begin
                    if (mem_ack) begin
                        mem_req_q <= 1'b0;
                        cmd_q.we  <= 1'b0;
                        err_q     <= 1'b0;
                        if (!cmd_q.we) begin
                            if (owner_q) d_rdata_q <= mem_rdata;
                            else         i_rdata_q <= mem_rdata;
                        end
                    end else if (timeout_hit) begin
                        mem_req_q <= 1'b0;
                        cmd_q.we  <= 1'b0;
                        err_q     <= 1'b1;
                        if (owner_q) d_rdata_q <= '0;
                        else         i_rdata_q <= '0;
                    end else if (wdog_cnt != '1) begin
                        wdog_cnt <= wdog_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = cmd_q.we;
    assign mem_addr  = cmd_q.addr;
    assign mem_wdata = cmd_q.wdata;
    assign busy      = (state != IDLE);
    assign owner     = owner_q;
    assign i_rvalid  = (state == RESP) && !owner_q;
    assign d_rvalid  = (state == RESP) && owner_q;
    assign i_err     = i_rvalid && err_q;
    assign d_err     = d_rvalid && err_q;
    assign i_rdata   = i_rdata_q;
    assign d_rdata   = d_rdata_q;

endmodule
